demux4_stream: RTL
==================

// Module: demux4_stream
//
// PURPOSE
//  Registered 1-to-4 stream demultiplexer; the counterpart of the 4:1 mux (mux4_1).
//  Routes one valid/ready input stream to one of four output channels O0..O3.
//  Channel comes from S1,S0 (direct mode) or from an internal round-robin pointer.
//  Each channel has a one-entry output buffer, so a stalled channel never blocks the others.
//
// PARAMETERS
//  WIDTH    8   data width of the input and of each output channel
//  CNT_W    8   width of the accepted-transfer counter
//
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  I          in   WIDTH   input data
//  I_valid    in   1       input word present
//  I_ready    out  1       input word accepted when I_valid & I_ready
//  S1,S0      in   1,1     channel select {S1,S0}; used only when rr_en=0
//  rr_en      in   1       1 = round-robin mode; S1,S0 ignored
//  O0..O3     out  WIDTH   channel data, registered
//  O0_valid..O3_valid   out  1   channel buffer holds a word
//  O0_ready..O3_ready   in   1   sink takes the word when Ox_valid & Ox_ready
//  cur_sel    out  2       channel the next accepted word goes to
//  xfer_cnt   out  CNT_W   total accepted input words, modulo 2^CNT_W
//
// BEHAVIOUR
//  - Reset (async assert, sync release): all Ox_valid=0, Ox=0, RR pointer=0, xfer_cnt=0.
//    While rst=1, I_ready=0. A word held mid-transfer is lost; no partial state survives.
//  - cur_sel = rr_en ? rr_ptr : {S1,S0}. It is combinational from current-cycle inputs.
//  - Channel x is "free" when !Ox_valid, or when Ox_valid & Ox_ready (drained this cycle).
//  - I_ready = free(cur_sel). It is combinational.
//  - Accept (I_valid & I_ready): on the next edge Ox<=I and Ox_valid<=1 for x=cur_sel.
//    Latency is 1 cycle from accept to Ox_valid. Throughput is 1 word/cycle per channel
//    when the sink is always ready.
//  - Drain without a new accept on that channel: Ox_valid<=0. Ox holds its last value.
//  - Drain and accept on the same channel in the same cycle: Ox_valid stays 1 and the new
//    data is loaded. No bubble.
//  - Non-selected channels drain independently in the same cycle.
//  - RR pointer: advances by 1 only on an accept while rr_en=1; wraps 3->0.
//    With no accept, or with rr_en=0, the pointer holds its value.
//  - Toggling rr_en takes effect on the same cycle's cur_sel. The pointer is retained
//    across mode changes; it is not reset.
//  - xfer_cnt increments by 1 on every accept in either mode and wraps 2^CNT_W-1 -> 0.
//  - Changing S1,S0 while I_valid=1 and I_ready=0 is legal. Routing uses the value present
//    in the accept cycle.
//  - Ox is not guaranteed stable while Ox_valid=0.
//
// STRUCTURE
//  - Shared package/header: CH0..CH3 = 2'd0..2'd3; default WIDTH and CNT_W.
//  - Sub-module demux_slot (instantiated 4x): one-entry buffer.
//    Inputs: clk, rst, load, d, ready. Outputs: q, valid, free.
//  - Top level: select/decode logic (2-to-4 one-hot load enables, a dual of the
//    mux4_1 decode), the RR pointer, xfer_cnt, and I_ready = mux of the four free signals.
//
// TESTING
//  1. Reset: assert rst mid-stream with O2_valid=1.
//     -> All Ox_valid=0, Ox=0, xfer_cnt=0, cur_sel=0 immediately (asynchronous),
//        I_ready=0 while rst=1.
//  2. Direct mode: rr_en=0; send I=8'hA5 with {S1,S0}=2'b10, all sinks ready.
//     -> Next cycle O2=8'hA5 with O2_valid=1, other channels' valid=0, xfer_cnt=1.
//  3. Back-pressure: O1_ready=0; send 8'h11 then 8'h22, both to ch1.
//     -> After the first, I_ready=0 while {S1,S0}=01. Switching to ch3 accepts 8'h22 into O3.
//        Raising O1_ready with ch1 still selected gives drain plus load in the same cycle,
//        with no bubble.
//  4. Round-robin: rr_en=1; 6 back-to-back words 1..6, sinks ready.
//     -> Words land on ch0,1,2,3,0,1; cur_sel=2 afterwards; S1,S0 have no effect.
//  5. RR stall: rr_en=1, O0_ready=0 with O0 full, pointer at 0.
//     -> I_ready=0 and the pointer holds at 0 (no skip). Releasing O0_ready accepts the
//        word to ch0 and the pointer advances to 1.
//  6. Counter wrap: CNT_W=8, 256 accepts -> xfer_cnt returns to 0, and 257 accepts -> 1.
//     Toggling rr_en mid-run keeps the pointer value.

Source files
------------

// File: rtl/demux4_stream_pkg.sv
// Shared constants and helpers for the 1-to-4 stream demultiplexer.
package demux4_stream_pkg;

  // Channel codes as seen on {S1,S0} and on cur_sel.
  localparam logic [1:0] CH0 = 2'd0;
  localparam logic [1:0] CH1 = 2'd1;
  localparam logic [1:0] CH2 = 2'd2;
  localparam logic [1:0] CH3 = 2'd3;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;

  // 2-to-4 one-hot decode: the dual of the 4:1 mux select.
  function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/demux4_stream_slot.sv
// One-entry output buffer for a single demux channel.
// A load always wins over a drain, so a drain and a load in the same
// cycle keep valid high with the new data (no bubble).
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             free
);

  // The buffer can take a word if it is empty or is being drained now.
  assign free = !valid || ready;

  // Buffer state: load new word, or clear valid when the sink takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: data is reset too because the outputs must read 0 after reset;
      // a plain pipeline register would normally only need valid reset.
      q     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      q     <= d;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux4_stream.sv
// Registered 1-to-4 valid/ready stream demultiplexer with direct
// ({S1,S0}) or round-robin channel selection and an accept counter.
module demux4_stream
  import demux4_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] I,
  input  logic             I_valid,
  output logic             I_ready,
  input  logic             S1,
  input  logic             S0,
  input  logic             rr_en,
  output logic [WIDTH-1:0] O0,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic [WIDTH-1:0] O3,
  output logic             O0_valid,
  output logic             O1_valid,
  output logic             O2_valid,
  output logic             O3_valid,
  input  logic             O0_ready,
  input  logic             O1_ready,
  input  logic             O2_ready,
  input  logic             O3_ready,
  output logic [1:0]       cur_sel,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic [1:0]       rr_ptr;
  logic [3:0]       free;
  logic [3:0]       load;
  logic [3:0]       sink_ready;
  logic [3:0]       slot_valid;
  logic [WIDTH-1:0] slot_q [4];
  logic             accept;

  // Channel the next accepted word goes to; switches with rr_en in the same cycle.
  assign cur_sel = rr_en ? rr_ptr : {S1, S0};

  // Input is ready only when the selected buffer can take a word and not in reset.
  assign I_ready = !rst && free[cur_sel];
  assign accept  = I_valid && I_ready;
  assign load    = accept ? sel_onehot(cur_sel) : 4'b0000;

  assign sink_ready = {O3_ready, O2_ready, O1_ready, O0_ready};

  for (genvar g = 0; g < 4; g++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[g]),
      .d     (I),
      .ready (sink_ready[g]),
      .q     (slot_q[g]),
      .valid (slot_valid[g]),
      .free  (free[g])
    );
  end

  assign O0 = slot_q[0];
  assign O1 = slot_q[1];
  assign O2 = slot_q[2];
  assign O3 = slot_q[3];
  assign {O3_valid, O2_valid, O1_valid, O0_valid} = slot_valid;

  // Round-robin pointer: steps only on a round-robin accept, kept across mode changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= CH0;
    else if (accept && rr_en)
      rr_ptr <= rr_ptr + 2'd1;
  end

  // Accepted-word counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      xfer_cnt <= '0;
    else if (accept)
      xfer_cnt <= xfer_cnt + CNT_W'(1);
  end

endmodule
